// File: rtl/pe_array_stream.sv
// pe_array_stream: NUM_PE-wide signed int8 MAC cluster with per-PE round/shift/saturate requant.
// Define PE_ARRAY_RELU_EN to clamp negative results to zero before saturation.
module pe_array_stream #(
    parameter int NUM_PE = 16,
    parameter int LANES  = 4,
    parameter int DW     = 8,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [CNT_W-1:0]          cfg_k_beats,
    input  logic [4:0]                cfg_shift,
    input  logic [NUM_PE-1:0]         pe_en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DW-1:0]       ifm,
    input  logic [NUM_PE*LANES*DW-1:0] weight,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_PE*DW-1:0]      ofm,
    output logic                      busy
);
    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] OUT   = 1'b1;
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (DW-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(1 << (DW-1)));

    function automatic logic signed [ACC_W-1:0] mac(
        input logic signed [ACC_W-1:0] a,
        input logic [LANES*DW-1:0]     x,
        input logic [LANES*DW-1:0]     w
    );
        logic signed [2*DW-1:0]  pr;
        logic signed [ACC_W-1:0] s;
        s = a;
        for (int i = 0; i < LANES; i++) begin
            pr = $signed(x[i*DW +: DW]) * $signed(w[i*DW +: DW]);
            s = s + {{(ACC_W-2*DW){pr[2*DW-1]}}, pr};
        end
        return s;
    endfunction

    // One extra bit so the rounding addend cannot overflow before the shift.
    function automatic logic [DW-1:0] requant(
        input logic signed [ACC_W-1:0] a,
        input logic [4:0]              sh
    );
        logic signed [ACC_W:0] r;
        r = (sh == 5'd0) ? (ACC_W+1)'(a)
                         : ((ACC_W+1)'(a) + ((ACC_W+1)'(1) <<< (sh - 5'd1))) >>> sh;
`ifdef PE_ARRAY_RELU_EN
        if (r < 0) r = '0;
`else
`endif
        return r > SAT_MAX ? SAT_MAX[DW-1:0] : r < SAT_MIN ? SAT_MIN[DW-1:0] : r[DW-1:0];
    endfunction

    logic [0:0]              state;
    logic [CNT_W-1:0]        cnt, k_reg, k_eff, k_cur;
    logic                    accept, last;
    logic signed [ACC_W-1:0] acc     [NUM_PE];
    logic signed [ACC_W-1:0] acc_nxt [NUM_PE];

    assign in_ready = state == ACCUM && !clear;
    assign accept   = in_valid && in_ready;
    assign k_eff    = cfg_k_beats == '0 ? CNT_W'(1) : cfg_k_beats;
    assign k_cur    = cnt == '0 ? k_eff : k_reg;
    assign last     = accept && cnt == k_cur - CNT_W'(1);
    assign busy     = cnt != '0 || out_valid;

    always_comb begin
        for (int p = 0; p < NUM_PE; p++)
            acc_nxt[p] = mac(acc[p], ifm, weight[p*LANES*DW +: LANES*DW]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            cnt       <= '0;
            k_reg     <= '0;
            ofm       <= '0;
            for (int p = 0; p < NUM_PE; p++) acc[p] <= '0;
        end else if (clear) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            cnt       <= '0;
            for (int p = 0; p < NUM_PE; p++) acc[p] <= '0;
        end else if (state == ACCUM) begin
            if (accept) begin
                cnt <= cnt + CNT_W'(1);
                for (int p = 0; p < NUM_PE; p++) acc[p] <= acc_nxt[p];
                if (cnt == '0) k_reg <= k_eff;
                if (last) begin
                    state     <= OUT;
                    out_valid <= 1'b1;
                    for (int p = 0; p < NUM_PE; p++)
                        ofm[p*DW +: DW] <= pe_en[p] ? requant(acc_nxt[p], cfg_shift) : '0;
                end
            end
        end else if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            cnt       <= '0;
            for (int p = 0; p < NUM_PE; p++) acc[p] <= '0;
        end
    end
endmodule

// File: tb/tb_pe_array_stream.sv
// tb_pe_array_stream: scoreboard bench for pe_array_stream; expected OFM vectors queued on the last beat.
module tb_pe_array_stream;
    localparam int NUM_PE = 16, LANES = 4, DW = 8, ACC_W = 24, CNT_W = 16;
`ifdef PE_ARRAY_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif
    typedef logic [NUM_PE*DW-1:0]       vec_t;
    typedef logic [NUM_PE*LANES*DW-1:0] w_t;

    logic clk = 0, reset = 1, clear = 0, in_valid = 0, out_ready = 1;
    logic [CNT_W-1:0] cfg_k_beats = 1;
    logic [4:0] cfg_shift = 0;
    logic [NUM_PE-1:0] pe_en = '1;
    logic [LANES*DW-1:0] ifm = '0;
    w_t weight = '0;
    logic in_ready, out_valid, busy;
    vec_t ofm;

    pe_array_stream #(.NUM_PE(NUM_PE), .LANES(LANES), .DW(DW), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .clear(clear), .cfg_k_beats(cfg_k_beats), .cfg_shift(cfg_shift),
        .pe_en(pe_en), .in_valid(in_valid), .in_ready(in_ready), .ifm(ifm), .weight(weight),
        .out_valid(out_valid), .out_ready(out_ready), .ofm(ofm), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    vec_t sb[$];
    logic signed [ACC_W-1:0] m_acc [NUM_PE];
    int m_cnt = 0, m_k = 1;

    task automatic chk(input string tag, input vec_t got, input vec_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rq_model(input longint a, input int s);
        longint d, t, r;
        if (s == 0) r = a;
        else begin
            d = longint'(1) << s;
            t = a + d / 2;
            r = t >= 0 ? t / d : -((-t + d - 1) / d);
        end
        if (RELU && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return 8'(r);
    endfunction

    function automatic w_t wset2(input logic [DW-1:0] w0, input logic [DW-1:0] w1);
        w_t w = '0;
        for (int i = 0; i < LANES; i++) begin
            w[i*DW +: DW] = w0;
            w[(LANES+i)*DW +: DW] = w1;
        end
        return w;
    endfunction

    task automatic model_zero();
        for (int p = 0; p < NUM_PE; p++) m_acc[p] = '0;
        m_cnt = 0;
    endtask

    task automatic model_accept(input logic [LANES*DW-1:0] x, input w_t w);
        vec_t e;
        int prod;
        if (m_cnt == 0) m_k = cfg_k_beats == 0 ? 1 : int'(cfg_k_beats);
        for (int p = 0; p < NUM_PE; p++)
            for (int i = 0; i < LANES; i++) begin
                prod = int'($signed(x[i*DW +: DW])) * int'($signed(w[(p*LANES+i)*DW +: DW]));
                m_acc[p] = m_acc[p] + ACC_W'(prod);
            end
        m_cnt++;
        if (m_cnt == m_k) begin
            for (int p = 0; p < NUM_PE; p++)
                e[p*DW +: DW] = pe_en[p] ? rq_model(longint'(m_acc[p]), int'(cfg_shift)) : '0;
            sb.push_back(e);
            model_zero();
        end
    endtask

    task automatic beat(input logic [LANES*DW-1:0] x, input w_t w);
        int budget = 0;
        @(negedge clk);
        ifm = x; weight = w; in_valid = 1;
        #1;
        while (!in_ready && budget < 50) begin
            @(negedge clk); #1; budget++;
        end
        if (!in_ready) begin
            chk("beat_timeout", vec_t'(in_ready), vec_t'(1));
            in_valid = 0;
            return;
        end
        @(posedge clk);
        model_accept(x, w);
        #1 in_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1;
        @(posedge clk); #1 reset = 0;
        model_zero();
        sb.delete();
    endtask

    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", vec_t'(out_valid), vec_t'(0));
            else chk("sb_ofm", ofm, sb.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t hold;
        w_t wr;
        int kk;
        model_zero();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_in_ready", vec_t'(in_ready), vec_t'(1));
        chk("rst_out_valid", vec_t'(out_valid), vec_t'(0));
        chk("rst_ofm", ofm, vec_t'(0));
        chk("rst_busy", vec_t'(busy), vec_t'(0));

        // k=1 dot product, one-cycle latency
        cfg_k_beats = 1; cfg_shift = 0;
        beat({8'd4, 8'd3, 8'd2, 8'd1}, wset2(8'd1, 8'hFF));
        @(negedge clk);
        chk("k1_out_valid", vec_t'(out_valid), vec_t'(1));
        chk("k1_in_ready", vec_t'(in_ready), vec_t'(0));
        chk("k1_ofm0", vec_t'(ofm[7:0]), vec_t'(8'd10));
        chk("k1_ofm1", vec_t'(ofm[15:8]), vec_t'(RELU ? 8'd0 : 8'hF6));

        // saturation both ways
        cfg_k_beats = 4; cfg_shift = 2;
        for (int b = 0; b < 4; b++) begin
            beat({4{8'd127}}, wset2(8'd127, 8'h80));
            if (b == 1) chk("sat_busy", vec_t'(busy), vec_t'(1));
        end
        @(negedge clk);
        chk("sat_ofm0", vec_t'(ofm[7:0]), vec_t'(8'd127));
        chk("sat_ofm1", vec_t'(ofm[15:8]), vec_t'(RELU ? 8'd0 : 8'h80));

        // rounding half up: 5 -> 3, -5 -> -2
        cfg_k_beats = 3; cfg_shift = 1;
        beat(32'h1, wset2(8'd2, 8'hFE));
        beat(32'h1, wset2(8'd2, 8'hFE));
        beat(32'h1, wset2(8'd1, 8'hFF));
        @(negedge clk);
        chk("rnd_ofm0", vec_t'(ofm[7:0]), vec_t'(8'd3));
        chk("rnd_ofm1", vec_t'(ofm[15:8]), vec_t'(RELU ? 8'd0 : 8'hFE));

        // cfg_k_beats=0 behaves as 1
        cfg_k_beats = 0; cfg_shift = 0;
        beat({4{8'd2}}, wset2(8'd3, 8'd1));
        @(negedge clk);
        chk("k0_out_valid", vec_t'(out_valid), vec_t'(1));
        chk("k0_ofm0", vec_t'(ofm[7:0]), vec_t'(8'd24));

        // backpressure: output held, offered beats ignored
        @(negedge clk);
        out_ready = 0; cfg_k_beats = 2; cfg_shift = 3;
        beat($urandom(), wset2(8'($urandom()), 8'($urandom())));
        beat($urandom(), wset2(8'($urandom()), 8'($urandom())));
        hold = ofm;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_out_valid", vec_t'(out_valid), vec_t'(1));
            chk("bp_ofm_stable", ofm, hold);
            chk("bp_in_ready", vec_t'(in_ready), vec_t'(0));
            ifm = 32'h7F7F7F7F; weight = wset2(8'd99, 8'd99); in_valid = 1;
        end
        out_ready = 1;
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        chk("bp_release_valid", vec_t'(out_valid), vec_t'(0));
        chk("bp_release_ready", vec_t'(in_ready), vec_t'(1));
        cfg_k_beats = 1; cfg_shift = 0;
        beat({4{8'd1}}, wset2(8'd5, 8'd0));
        @(negedge clk);
        chk("bp_next_ofm0", vec_t'(ofm[7:0]), vec_t'(8'd20));

        // abort mid-pass with clear, then with reset
        for (int mode = 0; mode < 2; mode++) begin
            cfg_k_beats = 4; cfg_shift = 0;
            beat({4{8'd10}}, wset2(8'd10, 8'd0));
            beat({4{8'd10}}, wset2(8'd10, 8'd0));
            if (mode == 0) begin
                @(negedge clk);
                clear = 1; in_valid = 1;
                #1 chk("clr_in_ready", vec_t'(in_ready), vec_t'(0));
                @(posedge clk);
                #1 clear = 0; in_valid = 0;
                model_zero();
            end else do_reset();
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk("abort_no_out", vec_t'(out_valid), vec_t'(0));
                chk("abort_busy", vec_t'(busy), vec_t'(0));
            end
            for (int b = 0; b < 4; b++) beat({4{8'd1}}, wset2(8'd1, 8'd0));
            @(negedge clk);
            chk("abort_out_valid", vec_t'(out_valid), vec_t'(1));
            chk("abort_ofm0", vec_t'(ofm[7:0]), vec_t'(8'd16));
        end

        // random passes, cfg_k_beats disturbed mid-pass
        for (int n = 0; n < 30; n++) begin
            kk = $urandom_range(0, 4);
            cfg_k_beats = CNT_W'(kk);
            cfg_shift = 5'($urandom_range(0, 16));
            pe_en = NUM_PE'($urandom());
            for (int b = 0; b < (kk == 0 ? 1 : kk); b++) begin
                for (int j = 0; j < NUM_PE; j++) wr[j*32 +: 32] = $urandom();
                beat($urandom(), wr);
                if (b == 0) cfg_k_beats = CNT_W'($urandom_range(1, 9));
            end
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", vec_t'(sb.size()), vec_t'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
